// File: rtl/idp_codec_07.sv
// 5-bit lane of the IDP TSV codec: registered crosstalk-avoiding encoder
// plus a zero-latency combinational decoder with a redundancy check.
module idp_codec_07 #(
    parameter int unsigned DATA_W = 5,
    parameter int unsigned TSV_W  = 7
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [DATA_W-1:0] datain,
    output logic [TSV_W-1:0]  tsv,
    input  logic [TSV_W-1:0]  tsv_in,
    output logic [DATA_W-1:0] dataout,
    output logic              code_err
);

    // Wires 1/2 and 3/4 carry duplicated bits, so every interior wire of
    // tsv[5:0] matches a neighbour and no isolated 010/101 can occur.
    function automatic logic [TSV_W-1:0] encode(input logic [DATA_W-1:0] d);
        return {d[4], d[3], d[2], d[2], d[1], d[1], d[0]};
    endfunction

    always_ff @(posedge clock) begin
        if (reset) begin
            tsv <= '0;
        end else begin
            tsv <= encode(datain);
        end
    end

    // Data is taken from wires 1 and 3; their copies only feed the check.
    always_comb begin
        dataout  = {tsv_in[6], tsv_in[5], tsv_in[3], tsv_in[1], tsv_in[0]};
        code_err = (tsv_in[1] != tsv_in[2]) | (tsv_in[3] != tsv_in[4]);
    end

endmodule

// File: tb/tb_idp_codec_07.sv
// Scoreboard bench for idp_codec_07 in loopback, with an override path on
// tsv_in for corrupted-codeword checks.
module tb_idp_codec_07;

    logic       clock = 1'b0;
    logic       reset;
    logic [4:0] datain;
    logic [6:0] tsv;
    logic [6:0] tsv_in;
    logic [4:0] dataout;
    logic       code_err;

    logic       force_en;
    logic [6:0] force_word;

    int unsigned total = 0;
    int unsigned bad   = 0;

    typedef struct {
        logic [6:0] code;
        logic [4:0] data;
    } exp_t;

    exp_t sb[$];

    assign tsv_in = force_en ? force_word : tsv;

    idp_codec_07 #(.DATA_W(5), .TSV_W(7)) dut (
        .clock    (clock),
        .reset    (reset),
        .datain   (datain),
        .tsv      (tsv),
        .tsv_in   (tsv_in),
        .dataout  (dataout),
        .code_err (code_err)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drive a word (truncated to 5 bits) and queue what the next edge should produce.
    task automatic drive(input int unsigned v, input logic rst);
        exp_t e;
        logic [4:0] d;
        d      = v[4:0];
        datain = d;
        reset  = rst;
        if (rst) begin
            e.code = 7'b0;
            e.data = 5'd0;
        end else begin
            e.code = {d[4], d[3], d[2], d[2], d[1], d[1], d[0]};
            e.data = d;
        end
        sb.push_back(e);
    endtask

    function automatic logic isolated(input logic [6:0] t);
        logic hit;
        hit = 1'b0;
        for (int j = 0; j <= 3; j++) begin
            if ((t[j] != t[j+1]) && (t[j+1] != t[j+2])) hit = 1'b1;
        end
        return hit;
    endfunction

    task automatic edge_check(input string tag, input logic full);
        exp_t e;
        @(posedge clock);
        #1;
        check({tag, "_sb"}, sb.size(), 1);
        if (sb.size() != 0) begin
            e = sb.pop_front();
            check({tag, "_err"}, code_err, 1'b0);
            check({tag, "_data"}, dataout, e.data);
            if (full) begin
                check({tag, "_tsv"}, tsv, e.code);
                check({tag, "_iso"}, isolated(tsv), 1'b0);
            end
        end
    endtask

    initial begin
        force_en   = 1'b0;
        force_word = 7'b0;
        datain     = 5'd0;
        reset      = 1'b1;

        drive(22, 1'b1);
        edge_check("reset", 1'b1);

        drive(22, 1'b0);  edge_check("d22", 1'b1);
        check("d22_lit", tsv, 7'b1011110);
        drive(10, 1'b0);  edge_check("d10", 1'b1);
        check("d10_lit", tsv, 7'b0100110);
        drive(21, 1'b0);  edge_check("d21", 1'b1);
        check("d21_lit", tsv, 7'b1011001);
        drive(0, 1'b0);   edge_check("d0", 1'b1);
        check("d0_lit", tsv, 7'h00);
        drive(31, 1'b0);  edge_check("d31", 1'b1);
        check("d31_lit", tsv, 7'h7F);

        // Mid-stream reset then resume
        drive(13, 1'b1);  edge_check("midrst", 1'b1);
        drive(13, 1'b0);  edge_check("resume", 1'b1);

        // Corrupted codewords on the receive side
        force_en   = 1'b1;
        force_word = 7'b0000010;
        #1;
        check("corr1_err", code_err, 1'b1);
        check("corr1_data", dataout, 5'd2);
        force_word = 7'b0001000;
        #1;
        check("corr2_err", code_err, 1'b1);
        check("corr2_data", dataout, 5'd4);
        force_word = 7'b0010000;
        #1;
        check("corr3_err", code_err, 1'b1);
        check("corr3_data", dataout, 5'd0);
        force_en = 1'b0;

        // Exhaustive sweep then random soak
        for (int unsigned i = 0; i < 32; i++) begin
            drive(i, 1'b0);
            edge_check("sweep", 1'b1);
        end
        for (int unsigned i = 0; i < 3000; i++) begin
            drive($urandom % 10000, 1'b0);
            edge_check("soak", 1'b1);
        end

        check("sb_drain", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
